// File: rtl/rns_residue_select.sv
// Per-channel RNS operand selector: two register stages with valid/ready
// backpressure, choosing residue, alternate, modular negation or masked mix.
module rns_residue_select #(
    parameter int               C      = 3,
    parameter int               W      = 4,
    parameter logic [C*W-1:0]   MODULI = {4'd9, 4'd8, 4'd7}
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [C*W-1:0] in_num,
    input  logic [C*W-1:0] in_comp,
    input  logic [1:0]     in_mode,
    input  logic [C-1:0]   in_mask,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [C*W-1:0] out_data,
    output logic [C-1:0]   out_err
);

    logic           r_s1_valid;
    logic [C*W-1:0] r_s1_num;
    logic [C*W-1:0] r_s1_comp;
    logic [1:0]     r_s1_mode;
    logic [C-1:0]   r_s1_mask;
    logic [C-1:0]   r_s1_err_num;
    logic [C-1:0]   r_s1_err_comp;

    logic           r_out_valid;
    logic [C*W-1:0] r_out_data;
    logic [C-1:0]   r_out_err;

    logic           w_s1_adv;
    logic           w_s2_adv;
    logic [C-1:0]   w_err_num;
    logic [C-1:0]   w_err_comp;
    logic [C*W-1:0] w_res;
    logic [C-1:0]   w_err;

    // Only out_ready reaches in_ready combinationally.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    genvar i;
    generate
        for (i = 0; i < C; i++) begin : g_ch
            logic [W-1:0] w_m;
            logic [W-1:0] w_n;
            logic [W-1:0] w_c;
            logic [W-1:0] w_neg;
            logic         w_pick_comp;
            logic         w_sel_err;
            logic [W-1:0] w_r;

            assign w_m = MODULI[i*W +: W];

            assign w_err_num[i]  = in_num[i*W +: W]  >= w_m;
            assign w_err_comp[i] = in_comp[i*W +: W] >= w_m;

            assign w_n = r_s1_num[i*W +: W];
            assign w_c = r_s1_comp[i*W +: W];
            // Mod-2^W difference equals the W+1-bit result truncated; only
            // consulted when num < m, so it is always in range.
            assign w_neg = w_m - w_n;

            assign w_pick_comp = (r_s1_mode == 2'd1) ||
                                 ((r_s1_mode == 2'd3) && r_s1_mask[i]);
            assign w_sel_err   = w_pick_comp ? r_s1_err_comp[i] : r_s1_err_num[i];

            always_comb begin
                w_r = w_n;
                case (r_s1_mode)
                    2'd0:    w_r = w_n;
                    2'd1:    w_r = w_c;
                    2'd2:    w_r = (w_n == '0) ? '0 : w_neg;
                    default: w_r = r_s1_mask[i] ? w_c : w_n;
                endcase
            end

            assign w_res[i*W +: W] = w_sel_err ? '0 : w_r;
            assign w_err[i]        = w_sel_err;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_num      <= in_num;
                    r_s1_comp     <= in_comp;
                    r_s1_mode     <= in_mode;
                    r_s1_mask     <= in_mask;
                    r_s1_err_num  <= w_err_num;
                    r_s1_err_comp <= w_err_comp;
                end
            end
            // Output registers hold while stalled so the result stays stable.
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_res;
                    r_out_err  <= w_err;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_rns_residue_select.sv
// Self-checking bench for rns_residue_select: directed cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_rns_residue_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_num;
    logic [11:0] in_comp;
    logic [1:0]  in_mode;
    logic [2:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_err;

    int total = 0;
    int bad   = 0;
    logic [14:0] q[$];

    always #5 clk = ~clk;

    rns_residue_select dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_num(in_num), .in_comp(in_comp), .in_mode(in_mode), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    // Reference: returns {err[2:0], data[11:0]} from the selection rules.
    function automatic logic [14:0] model(input logic [11:0] n, input logic [11:0] c,
                                          input logic [1:0] md, input logic [2:0] mk);
        int m[3];
        logic [11:0] d;
        logic [2:0]  e;
        m[0] = 7; m[1] = 8; m[2] = 9;
        d = '0; e = '0;
        for (int k = 0; k < 3; k++) begin
            int nv, cv, op, r;
            bit use_c;
            nv = int'(n[k*4 +: 4]);
            cv = int'(c[k*4 +: 4]);
            use_c = (md == 2'd1) || (md == 2'd3 && mk[k]);
            op = use_c ? cv : nv;
            if (op >= m[k]) begin
                e[k] = 1'b1;
                r = 0;
            end else if (md == 2'd2) begin
                r = (nv == 0) ? 0 : m[k] - nv;
            end else begin
                r = op;
            end
            d[k*4 +: 4] = 4'(r);
        end
        return {e, d};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_num = 12'h536; in_comp = 12'h172; in_mode = 2'd0; in_mask = 3'b000;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || out_data !== 12'h0 || out_err !== 3'b0) begin
                bad++;
                $display("FAIL reset_state: valid=%b data=%h err=%b, want 0/000/000",
                         out_valid, out_data, out_err);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_release c=%0d: in_ready=%b out_valid=%b, want 1/0",
                         c, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mode_sweep();
        logic [11:0] tn[6], tc[6], ed[6];
        logic [1:0]  tm[6];
        logic [2:0]  tk[6], ee[6];
        tn[0]=12'h536; tc[0]=12'h172; tm[0]=2'd0; tk[0]=3'b000; ed[0]=12'h536; ee[0]=3'b000;
        tn[1]=12'h536; tc[1]=12'h172; tm[1]=2'd1; tk[1]=3'b000; ed[1]=12'h172; ee[1]=3'b000;
        tn[2]=12'h536; tc[2]=12'h172; tm[2]=2'd2; tk[2]=3'b000; ed[2]=12'h451; ee[2]=3'b000;
        tn[3]=12'h536; tc[3]=12'h172; tm[3]=2'd3; tk[3]=3'b010; ed[3]=12'h576; ee[3]=3'b000;
        tn[4]=12'h087; tc[4]=12'h000; tm[4]=2'd2; tk[4]=3'b000; ed[4]=12'h000; ee[4]=3'b011;
        // mode 3 picking an out-of-range comp on ch2 only
        tn[5]=12'h123; tc[5]=12'hA00; tm[5]=2'd3; tk[5]=3'b100; ed[5]=12'h023; ee[5]=3'b100;
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1; in_num = tn[t]; in_comp = tc[t]; in_mode = tm[t]; in_mask = tk[t];
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL sweep_ready t=%0d: in_ready=%b want 1", t, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_num = 12'hFFF; in_comp = 12'hFFF;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL sweep_latency t=%0d: out_valid=%b after 1 cycle, want 0", t, out_valid);
            end
            @(posedge clk); #1;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== ed[t] || out_err !== ee[t]) begin
                bad++;
                $display("FAIL sweep_result t=%0d: valid=%b data=%h err=%b, want 1 %h %b",
                         t, out_valid, out_data, out_err, ed[t], ee[t]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        q.delete();
        in_comp = '0; in_mode = 2'd0; in_mask = '0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            in_valid  = (sent < 6);
            in_num    = {8'h00, 4'(sent)};
            out_ready = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (c >= 3 && c <= 7) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_ready c=%0d: in_ready=%b want 0 (pipe full)", c, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_num, in_comp, in_mode, in_mask));
                sent++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0 || {out_err, out_data} !== q[0]) begin
                    bad++;
                    $display("FAIL bp_data c=%0d: got %h want %h", c, {out_err, out_data},
                             (q.size() != 0) ? q[0] : 15'h7FFF);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (got != 6) begin
            bad++; $display("FAIL bp_count: got %0d results want 6", got);
        end
    endtask

    task automatic test_throughput();
        int sent = 0;
        q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_num = 12'($urandom); in_comp = 12'($urandom);
            in_mode = 2'($urandom); in_mask = 3'($urandom);
            @(negedge clk);
            total++;
            if (out_valid !== ((c >= 2 && c < 12) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL tput_valid c=%0d: out_valid=%b", c, out_valid);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_num, in_comp, in_mode, in_mask));
                sent++;
            end
            if (out_valid) begin
                total++;
                if (q.size() == 0 || {out_err, out_data} !== q[0]) begin
                    bad++; $display("FAIL tput_data c=%0d: got %h want %h", c, {out_err, out_data},
                                    (q.size() != 0) ? q[0] : 15'h7FFF);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        total++;
        if (sent != 10 || q.size() != 0) begin
            bad++; $display("FAIL tput_count: accepted %0d want 10, left %0d", sent, q.size());
        end
    endtask

    task automatic test_random();
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_num = 12'($urandom); in_comp = 12'($urandom);
            in_mode = 2'($urandom); in_mask = 3'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(model(in_num, in_comp, in_mode, in_mask));
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0 || {out_err, out_data} !== q[0]) begin
                    bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, {out_err, out_data},
                                    (q.size() != 0) ? q[0] : 15'h7FFF);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if ({out_err, out_data} !== q[0]) begin
                    bad++; $display("FAIL rand_drain: got %h want %h", {out_err, out_data}, q[0]);
                end
                void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rand_drain_timeout: %0d results missing", q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [14:0] exp;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_mask = '0; in_comp = '0;
        in_num = 12'h111;
        @(posedge clk); #1;
        in_num = 12'h222;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL midrst_flush c=%0d: out_valid=%b data=%h want 0", c, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_num = 12'h345; in_comp = 12'h000; in_mode = 2'd2; in_mask = '0;
        exp = model(in_num, in_comp, in_mode, in_mask);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_latency: out_valid=%b after 1 cycle want 0", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || {out_err, out_data} !== exp) begin
            bad++; $display("FAIL midrst_result: valid=%b got %h want 1 %h", out_valid, {out_err, out_data}, exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mode_sweep();
        test_backpressure();
        test_throughput();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
